// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared op encodings, FSM states and constants for the EX-stage
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_WIDTH = 32;

    // Quotient reported for any divide by zero, signed or unsigned
    localparam logic [DEF_WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_e;

    function automatic logic op_is_signed(input md_op_e op_i);
        return (op_i == MD_MULT) || (op_i == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_e op_i);
        return (op_i == MD_DIV) || (op_i == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational conditional negation, used both for taking
//               operand magnitudes and for correcting result signs.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_hi,
    input  logic [WIDTH-1:0] val_lo,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic             joint,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] w_cat;
    logic [2*WIDTH-1:0] w_cat_neg;

    assign w_cat     = {val_hi, val_lo};
    assign w_cat_neg = -w_cat;

    // joint: treat hi:lo as one double-width value negated by neg_hi
    always_comb begin
        res_hi = val_hi;
        res_lo = val_lo;
        if (joint) begin
            if (neg_hi) begin
                res_hi = w_cat_neg[2*WIDTH-1:WIDTH];
                res_lo = w_cat_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_hi) res_hi = -val_hi;
            if (neg_lo) res_lo = -val_lo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative shift-add multiply / restoring divide writing HI/LO,
//               with pipeline stall request. Option: MULDIV_EARLY_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hilo_we_hi,
    input  logic             hilo_we_lo,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    md_op_e             w_op;
    logic               w_in_signed;
    logic               w_in_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_early;
    logic               w_last;

    assign w_op        = md_op_e'(op);
    assign w_in_signed = op_is_signed(w_op);
    assign w_in_div    = op_is_div(w_op);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_in (
        .val_hi (src_a),
        .val_lo (src_b),
        .neg_hi (w_in_signed & src_a[WIDTH-1]),
        .neg_lo (w_in_signed & src_b[WIDTH-1]),
        .joint  (1'b0),
        .res_hi (w_mag_a),
        .res_lo (w_mag_b)
    );

    // acc holds the product for multiply, {remainder, dividend/quotient} for divide
    assign w_mul_sum  = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    assign w_div_step = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign w_acc_step = is_div_q ? w_div_step : w_mul_sum;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_out (
        .val_hi (w_acc_step[2*WIDTH-1:WIDTH]),
        .val_lo (w_acc_step[WIDTH-1:0]),
        .neg_hi (is_div_q ? rem_neg_q : neg_q),
        .neg_lo (neg_q),
        .joint  (~is_div_q),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // Finish once no set multiplier bits remain after this iteration's shift
    assign w_early = ~is_div_q & (mplr_q[WIDTH-1:1] == '0);
`else
    assign w_early = 1'b0;
`endif

    assign w_last = (cnt_q == CNT_W'(WIDTH - 1)) | w_early;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (hilo_we_hi) hi_d = hilo_wdata;
                if (hilo_we_lo) lo_d = hilo_wdata;
                if (start && !flush) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = w_in_div;
                    neg_d     = w_in_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    rem_neg_d = w_in_signed & src_a[WIDTH-1];
                    div0_d    = w_in_div & (src_b == '0);
                    acc_d     = w_in_div ? {{WIDTH{1'b0}}, w_mag_a} : '0;
                    mcand_d   = {{WIDTH{1'b0}}, (w_in_div ? w_mag_b : w_mag_a)};
                    mplr_d    = w_mag_b;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = w_acc_step;
                    if (!is_div_q) begin
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_q >> 1;
                    end
                    if (w_last) begin
                        state_d = DONE;
                        hi_d    = w_res_hi;
                        lo_d    = (is_div_q && div0_q) ? WIDTH'(DIV0_LO) : w_res_lo;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Gated by reset so a start held during reset cannot freeze the pipeline
    assign stall_req = reset & (((state_q == IDLE) & start & ~flush) | (state_q == RUN));
    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit with a behavioural
//               HI/LO and latency reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         hilo_we_hi;
    logic         hilo_we_lo;
    logic [W-1:0] hilo_wdata;
    logic         busy;
    logic         stall_req;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hilo_we_hi (hilo_we_hi),
        .hilo_we_lo (hilo_we_lo),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .stall_req  (stall_req),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result, computed with plain 64-bit arithmetic
    task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] eh, output logic [31:0] el);
        longint      sp, sq, sr;
        logic [63:0] up;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    eh = sr[31:0];
                    el = sq[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else begin
                    eh = a % b;
                    el = a / b;
                end
            end
        endcase
    endtask

    function automatic int exp_run(input logic [1:0] o, input logic [31:0] b);
        int n;
        logic [31:0] mag;
        n   = 32;
        mag = b;
`ifdef MULDIV_EARLY_OUT_EN
        if (o[1] == 1'b0) begin
            if (o == 2'b00 && b[31]) mag = -b;
            n = 0;
            while (mag != 32'd0) begin
                n++;
                mag = mag >> 1;
            end
            if (n < 1) n = 1;
        end
`else
        if (o == 2'b11 && mag == 32'd0) n = 32;
`endif
        return n;
    endfunction

    // Full transaction: start cycle, RUN cycles, DONE cycle, then idle
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit mthi_in_run);
        logic [31:0] eh, el, got_hi, got_lo, prev_hi;
        int run, stalls, done_cyc;
        ref_model(o, a, b, eh, el);
        run      = exp_run(o, b);
        stalls   = 0;
        done_cyc = 0;
        got_hi   = '0;
        got_lo   = '0;
        @(negedge clk);
        prev_hi = hi;
        start   = 1'b1;
        op      = o;
        src_a   = a;
        src_b   = b;
        for (int c = 1; c <= 60; c++) begin
            #1;
            if (mthi_in_run && c == 7) check_eq({tag, "_mthi_ignored"}, hi, prev_hi);
            if (done) begin
                done_cyc = c;
                got_hi   = hi;
                got_lo   = lo;
                check_eq({tag, "_stall_in_done"}, stall_req, 0);
                break;
            end
            if (stall_req) stalls++;
            @(negedge clk);
            start      = 1'b0;
            hilo_we_hi = 1'b0;
            if (mthi_in_run && c == 5) begin
                hilo_we_hi = 1'b1;
                hilo_wdata = 32'hDEAD_BEEF;
            end
        end
        check_eq({tag, "_done_cycle"}, done_cyc, run + 2);
        check_eq({tag, "_stall_cycles"}, stalls, run + 1);
        check_eq({tag, "_hi"}, got_hi, eh);
        check_eq({tag, "_lo"}, got_lo, el);
        @(negedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        logic [31:0] ph, pl;
        int done_seen;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        reset      = 1'b0;
        start      = 1'b1;
        op         = 2'b00;
        src_a      = '0;
        src_b      = '0;
        flush      = 1'b0;
        hilo_we_hi = 1'b0;
        hilo_we_lo = 1'b0;
        hilo_wdata = '0;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_stall", stall_req, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max_hi_abs", hi, 32'hFFFF_FFFE);
        do_op("mult_neg", 2'b00, -32'sd7, 32'd3, 1'b0);
        check_eq("mult_neg_lo_abs", lo, 32'hFFFF_FFEB);
        do_op("div_neg", 2'b10, -32'sd7, 32'd2, 1'b0);
        check_eq("div_neg_abs", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0);
        check_eq("divu_zero_abs", {hi, lo}, {32'h0000_0064, 32'hFFFF_FFFF});
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_ovf_abs", {hi, lo}, {32'h0, 32'h8000_0000});
        do_op("div_zero_s", 2'b10, -32'sd9, 32'd0, 1'b0);

        // Flush during RUN cycle 10 of DIVU 50/7
        ph = hi;
        pl = lo;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        src_a = 32'd50;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check_eq("flush_busy_before", busy, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_stall", stall_req, 0);
        check_eq("flush_hilo_kept", {hi, lo}, {ph, pl});
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) done_seen++;
        end
        check_eq("flush_no_done", done_seen, 0);

        // Start together with flush in IDLE is dropped
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        #1;
        check_eq("start_flush_stall", stall_req, 0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("start_flush_busy", busy, 0);

        // MTLO / MTHI in IDLE
        ph = hi;
        hilo_we_lo = 1'b1;
        hilo_wdata = 32'h0000_1234;
        @(negedge clk);
        hilo_we_lo = 1'b0;
        #1;
        check_eq("mtlo_lo", lo, 32'h0000_1234);
        check_eq("mtlo_hi_kept", hi, ph);
        hilo_we_hi = 1'b1;
        hilo_wdata = 32'h0000_A5A5;
        @(negedge clk);
        hilo_we_hi = 1'b0;
        #1;
        check_eq("mthi_hi", hi, 32'h0000_A5A5);
        do_op("mthi_run", 2'b00, 32'd1234, -32'sd56, 1'b1);

        // Asynchronous reset between edges in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'h0001_FFFF;
        src_b = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        start = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_stall", stall_req, 0);
        check_eq("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        do_op("multu_6x7", 2'b01, 32'd6, 32'd7, 1'b0);
        do_op("multu_5x1", 2'b01, 32'd5, 32'd1, 1'b0);
        do_op("mult_by0", 2'b00, 32'h1234_5678, 32'd0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(0, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = $urandom_range(0, 255);
                4: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), ro, ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded operands regA_EX/regB_EX and a decoded mul/div op.
- Runs a multi-cycle shift-add multiply or restoring divide and writes the architectural HI/LO registers.
- Raises a stall request so the hazard logic freezes IF/ID/EX until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  op valid this cycle; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend (regA_EX after forwarding)
- src_b  in  WIDTH  multiplier / divisor (regB_EX after forwarding)
- flush  in  1  synchronous abort from branch/exception logic
- hilo_we_hi  in  1  MTHI write enable
- hilo_we_lo  in  1  MTLO write enable
- hilo_wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  state != IDLE
- stall_req  out  1  pipeline freeze request
- done  out  1  one-cycle pulse, result committed
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- States:
  - IDLE -> RUN on start & ~flush. At this edge the unit latches op and the operand magnitudes (signed ops take absolute values and record the result signs), and clears cnt.
  - RUN: one iteration per cycle; cnt increments. On the edge where cnt==WIDTH-1 the unit enters DONE and commits hi/lo.
  - DONE -> IDLE unconditionally on the next edge.
- Latency:
  - Start cycle, then 32 RUN cycles, then 1 DONE cycle.
  - New hi/lo are visible in the DONE cycle.
- stall_req = (start & IDLE & ~flush) | RUN. It is combinational, so it asserts in the start cycle itself. It is low in DONE so the dependent MFHI/MFLO proceeds.
- done = (state==DONE). It is registered.
- Multiply:
  - 2*WIDTH product accumulator; radix-2 shift-add.
  - If signs differed, the final product is two's-complement negated.
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Restoring algorithm; lo = quotient, hi = remainder.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0.
- Divide by zero:
  - Detected at start. The unit still runs the full latency.
  - Commits hi=src_a (as latched), lo=0xFFFFFFFF, for both signed and unsigned ops.
- start while busy: ignored. Upstream is stalled, so this is not expected.
- flush:
  - In RUN: go to IDLE next edge; hi/lo unchanged; no done.
  - Concurrent with start in IDLE: start ignored.
  - In DONE: no effect, because the commit has already happened.
- MTHI/MTLO:
  - Honoured only in IDLE, updating hi/lo on the next edge.
  - Ignored in RUN/DONE.
  - hilo_we_* together with start in IDLE: the write takes effect; the later completion overwrites it.
- Reset (any time, including mid-operation): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, stall_req=0 (start is ignored while reset is low). All internal accumulators are cleared.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - In multiply RUN, when the remaining (shifted) multiplier bits are all zero, the unit enters DONE on the next edge.
  - Minimum is 1 RUN cycle; a multiplier of 0 completes after 1 RUN cycle.
  - Divide is unaffected.
- Undefined: fixed 32-cycle RUN for all ops.

Decomposition:
- Shared package (cpu_pkg):
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state enum IDLE/RUN/DONE
  - WIDTH default
  - DIV0_LO constant 0xFFFFFFFF
- One natural sub-module: muldiv_sign_fix. It is combinational abs/negate for operand pre-conditioning and result post-correction, instantiated twice (in and out).
- The FSM, counter and datapath stay in the top.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall_req high for 33 cycles from start; done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU 100 / 0 -> full latency; hi=0x00000064, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Flush asserted at RUN cycle 10 of DIVU 50/7 -> IDLE next cycle; hi/lo keep prior values; done never pulses; stall_req drops.
5. reset pulled low asynchronously mid-RUN, between clock edges -> busy/stall_req/hi/lo go to 0 immediately. A new MULTU 6 x 7 afterwards gives lo=42, hi=0.
6. MTLO 0x1234 in IDLE -> lo=0x1234 next cycle. MTHI during RUN -> ignored. With MULDIV_EARLY_OUT_EN, MULTU 5 x 1 -> done after 1 RUN cycle, lo=5.
